// File: rtl/ifetch_pcgen.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pcgen
// Purpose  : Fetch-PC owner and instruction-bus requester feeding the fetch
//            stage. Optional misaligned-PC fault: IFETCH_MISALIGN_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ifetch_pcgen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [63:0] r_redir_pc, w_redir_pc_nxt;
    logic        r_discard, w_discard_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [63:0] r_instr_pc, w_instr_pc_nxt;
    logic        w_misalign;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_instr    <= 32'd0;
            r_instr_pc <= 64'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
        r_redir_pc <= w_redir_pc_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redir_pc_nxt = r_redir_pc;
        w_discard_nxt  = r_discard;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) w_pc_nxt = redirect_pc;
            end
            S_REQ: begin
                if (w_misalign) begin
                    // No bus request is outstanding, so a redirect retargets directly.
                    if (redirect_valid) begin
                        w_pc_nxt = redirect_pc;
                    end else begin
                        w_instr_nxt    = 32'd0;
                        w_instr_pc_nxt = r_pc;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (iresp_data_ok) begin
                    w_discard_nxt = 1'b0;
                    if (redirect_valid) begin
                        w_pc_nxt = redirect_pc;
                    end else if (r_discard) begin
                        w_pc_nxt = r_redir_pc;
                    end else begin
                        w_instr_nxt    = iresp_data;
                        w_instr_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + PC_STEP;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay stable until data_ok; remember the target.
                    w_redir_pc_nxt = redirect_pc;
                    w_discard_nxt  = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (out_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic r_mis, w_mis_nxt;

    assign w_misalign = (r_pc[1:0] != 2'b00);

    always_comb begin
        w_mis_nxt = r_mis;
        if (r_state == S_REQ) w_mis_nxt = w_misalign;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_mis <= 1'b0;
        else        r_mis <= w_mis_nxt;
    end

    assign out_misalign = (r_state == S_HOLD) && r_mis;
`else
    assign w_misalign   = 1'b0;
    assign out_misalign = 1'b0;
`endif

    assign ireq_valid = (r_state == S_REQ) && !w_misalign;
    assign ireq_addr  = ireq_valid ? r_pc : 64'd0;
    assign out_valid  = (r_state == S_HOLD);
    assign out_instr  = r_instr;
    assign out_pc     = r_instr_pc;

endmodule
`default_nettype wire
